// File: rtl/uart_rx_deser_param.sv
// -----------------------------------------------------------------------------
// uart_rx_deser_param
//
// Serial-to-parallel converter for the UART receive path. It takes one bit per
// sample strobe from the data sampler and assembles a word whose length is
// chosen at runtime. Bits can arrive LSB-first or MSB-first. The finished word
// is delivered with a one-cycle valid pulse, together with its XOR parity for
// the downstream parity checker. If the RX FSM drops the frame-active level
// before the word is complete, the partial word is discarded and a one-cycle
// abort pulse is raised.
//
// Parameters
//   DATA_WIDTH   maximum word width (5..15)
//   CNT_WIDTH    width of data_len; 2**CNT_WIDTH must exceed DATA_WIDTH
//
// Ports
//   CLK          receive clock
//   RST          asynchronous active-low reset
//   deser_en     frame-active level from the RX FSM
//   sample_vld   one-cycle strobe qualifying sampled_bit
//   sampled_bit  majority-voted data bit
//   data_len     bits per word, latched on the first bit of a frame
//   msb_first    bit order, latched on the first bit (0 = LSB first)
//   P_DATA       last completed word; bits at index >= len read 0
//   P_PAR        XOR of the len bits of P_DATA
//   data_valid   one-cycle pulse when P_DATA/P_PAR update
//   frame_abort  one-cycle pulse when a partial frame is discarded
//   busy         high while a frame is being shifted in
// -----------------------------------------------------------------------------
module uart_rx_deser_param #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  deser_en,
    input  logic                  sample_vld,
    input  logic                  sampled_bit,
    input  logic [CNT_WIDTH-1:0]  data_len,
    input  logic                  msb_first,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  P_PAR,
    output logic                  data_valid,
    output logic                  frame_abort,
    output logic                  busy
);

    localparam logic [CNT_WIDTH-1:0] LP_MAXLEN = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] LP_MINLEN = CNT_WIDTH'(5);
    localparam logic [CNT_WIDTH-1:0] LP_ONE    = CNT_WIDTH'(1);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_len;
    logic                  r_msb;
    logic [DATA_WIDTH-1:0] r_sreg;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_par;
    logic [DATA_WIDTH-1:0] r_pData;
    logic                  r_pPar;
    logic                  r_dataValid;
    logic                  r_frameAbort;
    logic                  r_busy;

    logic                  w_start;
    logic [CNT_WIDTH-1:0]  w_lenIn;
    logic [CNT_WIDTH-1:0]  w_lenUse;
    logic                  w_msbUse;
    logic [CNT_WIDTH-1:0]  w_k;
    logic [CNT_WIDTH-1:0]  w_pos;
    logic [CNT_WIDTH-1:0]  w_cntNext;
    logic [DATA_WIDTH-1:0] w_sregNext;
    logic [DATA_WIDTH-1:0] w_mask;
    logic                  w_parNext;
    logic                  w_lastBit;

    // Next-value datapath for a single accepted strobe. In IDLE the strobe is
    // bit 0 of a new frame, so length/order come straight from the inputs and
    // the shift register and parity start from zero; in SHIFT the latched
    // frame settings and the running values are used instead.
    always_comb begin
        w_start  = (r_state == ST_IDLE);
        // Out-of-range lengths fall back to the full word width.
        w_lenIn  = ((data_len < LP_MINLEN) || (data_len > LP_MAXLEN)) ? LP_MAXLEN : data_len;
        w_lenUse = w_start ? w_lenIn   : r_len;
        w_msbUse = w_start ? msb_first : r_msb;
        w_k      = w_start ? '0        : r_cnt;
        w_pos    = w_msbUse ? (w_lenUse - LP_ONE - w_k) : w_k;
        w_cntNext = w_k + LP_ONE;
        w_lastBit = (w_cntNext == w_lenUse);
        w_parNext = (w_start ? 1'b0 : r_par) ^ sampled_bit;

        w_sregNext = w_start ? '0 : r_sreg;
        w_mask     = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (CNT_WIDTH'(i) == w_pos) begin
                w_sregNext[i] = sampled_bit;
            end
            w_mask[i] = (CNT_WIDTH'(i) < w_lenUse);
        end
    end

    // Frame FSM with registered outputs. data_valid and frame_abort default
    // low every cycle so they can only ever be single-cycle pulses, and the
    // two are raised on mutually exclusive branches.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= ST_IDLE;
            r_len        <= LP_MAXLEN;
            r_msb        <= 1'b0;
            r_sreg       <= '0;
            r_cnt        <= '0;
            r_par        <= 1'b0;
            r_pData      <= '0;
            r_pPar       <= 1'b0;
            r_dataValid  <= 1'b0;
            r_frameAbort <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_dataValid  <= 1'b0;
            r_frameAbort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (deser_en && sample_vld) begin
                        r_len   <= w_lenIn;
                        r_msb   <= msb_first;
                        r_sreg  <= w_sregNext;
                        r_cnt   <= w_cntNext;
                        r_par   <= w_parNext;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!deser_en) begin
                        // Frame dropped by the RX FSM: any strobe this cycle is
                        // ignored and the last good word stays on P_DATA.
                        r_sreg       <= '0;
                        r_cnt        <= '0;
                        r_par        <= 1'b0;
                        r_frameAbort <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else if (sample_vld) begin
                        if (w_lastBit) begin
                            r_pData     <= w_sregNext & w_mask;
                            r_pPar      <= w_parNext;
                            r_dataValid <= 1'b1;
                            r_sreg      <= '0;
                            r_cnt       <= '0;
                            r_par       <= 1'b0;
                            r_busy      <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_sreg <= w_sregNext;
                            r_cnt  <= w_cntNext;
                            r_par  <= w_parNext;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign P_DATA      = r_pData;
    assign P_PAR       = r_pPar;
    assign data_valid  = r_dataValid;
    assign frame_abort = r_frameAbort;
    assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_deser_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deser_param
//
// Self-checking bench for uart_rx_deser_param (DATA_WIDTH=8, CNT_WIDTH=4).
// Directed scenarios cover reset, bit order, length clamping, abort and
// back-to-back frames; a randomized scenario compares every frame against a
// word/parity model built from the frame rules with plain arithmetic.
// Inputs change on the falling clock edge and outputs are read there too.
// -----------------------------------------------------------------------------
module tb_uart_rx_deser_param;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          deser_en;
    logic          sample_vld;
    logic          sampled_bit;
    logic [CW-1:0] data_len;
    logic          msb_first;
    logic [DW-1:0] P_DATA;
    logic          P_PAR;
    logic          data_valid;
    logic          frame_abort;
    logic          busy;

    int testsRun    = 0;
    int testsFailed = 0;

    uart_rx_deser_param #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .deser_en    (deser_en),
        .sample_vld  (sample_vld),
        .sampled_bit (sampled_bit),
        .data_len    (data_len),
        .msb_first   (msb_first),
        .P_DATA      (P_DATA),
        .P_PAR       (P_PAR),
        .data_valid  (data_valid),
        .frame_abort (frame_abort),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    // Reference model: effective frame length after clamping.
    function automatic int effLen(input int dl);
        return ((dl < 5) || (dl > DW)) ? DW : dl;
    endfunction

    // Reference model: bit k of the send order lands at k (LSB first) or at
    // len-1-k (MSB first); nothing is placed at or above len.
    function automatic logic [DW-1:0] modelWord(input logic [15:0] bits, input int len, input logic msb);
        int w;
        w = 0;
        for (int k = 0; k < len; k++) begin
            if (bits[k]) w = w + (1 << (msb ? (len - 1 - k) : k));
        end
        return DW'(w);
    endfunction

    function automatic logic modelPar(input logic [15:0] bits, input int len);
        int ones;
        ones = 0;
        for (int k = 0; k < len; k++) ones = ones + int'(bits[k]);
        return logic'(ones % 2);
    endfunction

    // Drive one strobe for a single cycle; called and returns on a falling edge.
    task automatic applyStimulus(input logic b);
        sample_vld  = 1'b1;
        sampled_bit = b;
        @(negedge CLK);
        sample_vld  = 1'b0;
        sampled_bit = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    // Send n bits (bits[0] first) with gap idle cycles between strobes and none
    // after the last, so the caller lands in the cycle that should carry data_valid.
    task automatic sendFrame(input logic [15:0] bits, input int n, input logic msb,
                             input logic [CW-1:0] dl, input int gap);
        data_len  = dl;
        msb_first = msb;
        deser_en  = 1'b1;
        for (int k = 0; k < n; k++) begin
            applyStimulus(bits[k]);
            if (k < n - 1) idleCycles(gap);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; deser_en = 1'b0; sample_vld = 1'b0; sampled_bit = 1'b0;
        data_len = 4'd8; msb_first = 1'b0;
        idleCycles(3);
        testsRun++;
        if ({P_DATA, P_PAR, data_valid, frame_abort, busy} !== 12'h000) begin
            testsFailed++;
            $display("[TB] FAIL resetState: got %h expected 000", {P_DATA, P_PAR, data_valid, frame_abort, busy});
        end
        RST = 1'b1;
        idleCycles(1);
        // Complete a frame so P_DATA is non-zero before the mid-frame reset.
        sendFrame(16'h00FF, 8, 1'b0, 4'd8, 1);
        testsRun++;
        if (P_DATA !== 8'hFF) begin
            testsFailed++;
            $display("[TB] FAIL resetPreFrame: got %h expected ff", P_DATA);
        end
        idleCycles(2);
        sendFrame(16'h0005, 3, 1'b0, 4'd8, 2);
        testsRun++;
        if (busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL resetBusyMid: got %b expected 1", busy);
        end
        #2 RST = 1'b0;
        #1;
        testsRun++;
        if ({P_DATA, P_PAR, data_valid, frame_abort, busy} !== 12'h000) begin
            testsFailed++;
            $display("[TB] FAIL resetMidFrame: got %h expected 000", {P_DATA, P_PAR, data_valid, frame_abort, busy});
        end
        @(negedge CLK);
        RST = 1'b1;
        idleCycles(2);
        testsRun++;
        if ({data_valid, frame_abort} !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL resetNoPulse: got %b expected 00", {data_valid, frame_abort});
        end
        sendFrame(16'h00A5, 8, 1'b0, 4'd8, 1);
        testsRun++;
        if ({data_valid, P_DATA, P_PAR} !== {1'b1, 8'hA5, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL resetAfterFrame: got %b/%h/%b expected 1/a5/0", data_valid, P_DATA, P_PAR);
        end
        deser_en = 1'b0;
        idleCycles(2);
    endtask

    task automatic test_lsb_first();
        sendFrame(16'h00A5, 8, 1'b0, 4'd8, 16);
        testsRun++;
        if ({data_valid, busy, P_DATA, P_PAR} !== {1'b1, 1'b0, 8'hA5, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL lsbA5: got dv=%b busy=%b data=%h par=%b expected 1/0/a5/0", data_valid, busy, P_DATA, P_PAR);
        end
        idleCycles(1);
        testsRun++;
        if (data_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL lsbPulseWidth: got %b expected 0", data_valid);
        end
        deser_en = 1'b0;
        idleCycles(2);
    endtask

    task automatic test_msb_first();
        sendFrame(16'h0041, 7, 1'b1, 4'd7, 2);
        testsRun++;
        if ({data_valid, P_DATA, P_PAR} !== {1'b1, 8'h41, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL msb41: got %b/%h/%b expected 1/41/0", data_valid, P_DATA, P_PAR);
        end
        idleCycles(2);
        sendFrame(16'h0041, 7, 1'b0, 4'd7, 2);
        testsRun++;
        if ({data_valid, P_DATA, P_PAR} !== {1'b1, 8'h41, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL lsb41: got %b/%h/%b expected 1/41/0", data_valid, P_DATA, P_PAR);
        end
        idleCycles(2);
        sendFrame(16'h0003, 7, 1'b0, 4'd7, 2);
        testsRun++;
        if ({data_valid, P_DATA, P_PAR} !== {1'b1, 8'h03, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL lsb03: got %b/%h/%b expected 1/03/0", data_valid, P_DATA, P_PAR);
        end
        deser_en = 1'b0;
        idleCycles(2);
    endtask

    task automatic test_clamp();
        logic [15:0] bits;
        logic [CW-1:0] lens [2];
        lens[0] = 4'd3;
        lens[1] = 4'd12;
        for (int f = 0; f < 2; f++) begin
            bits = 16'($urandom);
            data_len  = lens[f];
            msb_first = 1'($urandom);
            deser_en  = 1'b1;
            for (int k = 0; k < 8; k++) begin
                applyStimulus(bits[k]);
                // A mid-frame length change must be ignored.
                if (k == 0) data_len = 4'd5;
                testsRun++;
                if (data_valid !== (k == 7)) begin
                    testsFailed++;
                    $display("[TB] FAIL clampValid len=%0d strobe=%0d: got %b expected %b", lens[f], k, data_valid, (k == 7));
                end
            end
            testsRun++;
            if ({P_DATA, P_PAR} !== {modelWord(bits, 8, msb_first), modelPar(bits, 8)}) begin
                testsFailed++;
                $display("[TB] FAIL clampData len=%0d: got %h/%b expected %h/%b", lens[f], P_DATA, P_PAR,
                         modelWord(bits, 8, msb_first), modelPar(bits, 8));
            end
            idleCycles(1);
        end
        deser_en = 1'b0;
        idleCycles(2);
    endtask

    task automatic test_abort();
        sendFrame(16'h00A5, 8, 1'b0, 4'd8, 1);
        idleCycles(2);
        sendFrame(16'h000F, 4, 1'b0, 4'd8, 1);
        deser_en    = 1'b0;
        sample_vld  = 1'b1;
        sampled_bit = 1'b1;
        @(negedge CLK);
        sample_vld  = 1'b0;
        sampled_bit = 1'b0;
        testsRun++;
        if ({frame_abort, data_valid, busy, P_DATA} !== {1'b1, 1'b0, 1'b0, 8'hA5}) begin
            testsFailed++;
            $display("[TB] FAIL abortPulse: got fa=%b dv=%b busy=%b data=%h expected 1/0/0/a5",
                     frame_abort, data_valid, busy, P_DATA);
        end
        idleCycles(1);
        testsRun++;
        if ({frame_abort, data_valid} !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL abortOnce: got %b expected 00", {frame_abort, data_valid});
        end
        sendFrame(16'h00FF, 8, 1'b0, 4'd8, 1);
        testsRun++;
        if ({data_valid, P_DATA, P_PAR} !== {1'b1, 8'hFF, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL abortNext: got %b/%h/%b expected 1/ff/0", data_valid, P_DATA, P_PAR);
        end
        deser_en = 1'b0;
        idleCycles(2);
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits;
        bits = 16'($urandom);
        sendFrame(bits, 8, 1'b0, 4'd8, 0);
        testsRun++;
        if ({data_valid, P_DATA} !== {1'b1, modelWord(bits, 8, 1'b0)}) begin
            testsFailed++;
            $display("[TB] FAIL b2bFirst: got %b/%h expected 1/%h", data_valid, P_DATA, modelWord(bits, 8, 1'b0));
        end
        sendFrame(16'h0013, 5, 1'b0, 4'd5, 0);
        testsRun++;
        if ({data_valid, P_DATA, P_PAR} !== {1'b1, 8'h13, 1'b1}) begin
            testsFailed++;
            $display("[TB] FAIL b2bSecond: got %b/%h/%b expected 1/13/1", data_valid, P_DATA, P_PAR);
        end
        // Strobes while deser_en is low must not start a frame.
        deser_en = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus(1'($urandom));
        testsRun++;
        if ({busy, data_valid, frame_abort, P_DATA} !== {3'b000, 8'h13}) begin
            testsFailed++;
            $display("[TB] FAIL b2bIgnored: got busy=%b dv=%b fa=%b data=%h expected 0/0/0/13",
                     busy, data_valid, frame_abort, P_DATA);
        end
        idleCycles(2);
    endtask

    task automatic test_random();
        logic [15:0]   bits;
        logic [CW-1:0] dl;
        logic          msb;
        int            len;
        for (int f = 0; f < 24; f++) begin
            bits = 16'($urandom);
            dl   = CW'($urandom_range(0, 15));
            msb  = 1'($urandom);
            len  = effLen(int'(dl));
            sendFrame(bits, len, msb, dl, $urandom_range(0, 3));
            testsRun++;
            if ({data_valid, busy, P_DATA, P_PAR} !== {1'b1, 1'b0, modelWord(bits, len, msb), modelPar(bits, len)}) begin
                testsFailed++;
                $display("[TB] FAIL random%0d len=%0d msb=%b: got dv=%b busy=%b %h/%b expected 1/0/%h/%b",
                         f, len, msb, data_valid, busy, P_DATA, P_PAR, modelWord(bits, len, msb), modelPar(bits, len));
            end
            deser_en = 1'($urandom);
            idleCycles($urandom_range(0, 2));
        end
        deser_en = 1'b0;
        idleCycles(2);
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_clamp();
        test_abort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
